// File: rtl/spi_reg_port.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_port
// Purpose  : SPI mode-0 slave bridging a two-byte frame (cmd, data) onto a
//            simple register bus. cmd[7]=1 writes the data byte to address
//            cmd[6:0]; cmd[7]=0 reads the selector and shifts it out on miso.
//            All SPI inputs are oversampled by clk through synchronizers.
// Ports    : clk, rst_n          - system clock, async active-low reset
//            sck, cs_n, mosi     - SPI inputs (asynchronous to clk)
//            miso, miso_oe       - SPI serial out and its output enable
//            addr                - register address {1'b0, cmd[6:0]}
//            rd_data             - combinational readback for addr
//            wr_data, wr_strobe  - write byte and its one-clk qualifier
//            rd_strobe           - one-clk pulse when a read is issued
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_port #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic [7:0] addr,
  input  logic [7:0] rd_data,
  output logic [7:0] wr_data,
  output logic       wr_strobe,
  output logic       rd_strobe
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  // Fills with ones after reset; once full every synchronizer stage holds a
  // real sample of the pins instead of its reset value.
  logic [SYNC_STAGES-1:0] prime_q;

  state_t     state;
  logic       armed;
  logic [2:0] bit_cnt;
  logic [6:0] cmd_sr;
  logic [6:0] rx_sr;
  logic [7:0] tx_sr;
  logic       is_write;
  logic       first_fall;

  logic cs_s;
  logic mosi_s;
  logic primed;
  logic sck_rise;
  logic sck_fall;

  assign cs_s     = cs_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_q[SYNC_STAGES-1];
  assign primed   = prime_q[SYNC_STAGES-1];
  assign sck_rise = sck_q[SYNC_STAGES-2] & ~sck_q[SYNC_STAGES-1];
  assign sck_fall = ~sck_q[SYNC_STAGES-2] & sck_q[SYNC_STAGES-1];
  assign miso_oe  = ~cs_s;

  // Input synchronizers, reset to the bus idle levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q   <= '0;
      cs_q    <= '1;
      mosi_q  <= '0;
      prime_q <= '0;
    end else begin
      sck_q   <= {sck_q[SYNC_STAGES-2:0], sck};
      cs_q    <= {cs_q[SYNC_STAGES-2:0], cs_n};
      mosi_q  <= {mosi_q[SYNC_STAGES-2:0], mosi};
      prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Frame state machine with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      armed      <= 1'b0;
      bit_cnt    <= 3'd0;
      cmd_sr     <= 7'd0;
      rx_sr      <= 7'd0;
      tx_sr      <= 8'd0;
      is_write   <= 1'b0;
      first_fall <= 1'b0;
      miso       <= 1'b0;
      addr       <= 8'h00;
      wr_data    <= 8'h00;
      wr_strobe  <= 1'b0;
      rd_strobe  <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;

      // A frame may only start after a genuine cs_n high has been seen
      // following reset, so a frame cut by reset is never resumed.
      if (primed && cs_s) begin
        armed <= 1'b1;
      end

      case (state)
        IDLE: begin
          bit_cnt <= 3'd0;
          miso    <= 1'b0;
          if (armed && !cs_s) begin
            state <= CMD;
          end
        end

        CMD: begin
          if (cs_s) begin
            state <= IDLE;
            miso  <= 1'b0;
          end else begin
            miso <= 1'b0;
            if (sck_rise) begin
              cmd_sr  <= {cmd_sr[5:0], mosi_s};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                // cmd_sr[6] holds cmd[7], the write flag.
                addr       <= {1'b0, cmd_sr[5:0], mosi_s};
                is_write   <= cmd_sr[6];
                rd_strobe  <= ~cmd_sr[6];
                first_fall <= 1'b1;
                state      <= DATA;
              end
            end
          end
        end

        DATA: begin
          if (cs_s) begin
            state <= IDLE;
            miso  <= 1'b0;
          end else if (sck_rise) begin
            rx_sr   <= {rx_sr[5:0], mosi_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (is_write) begin
                wr_data   <= {rx_sr, mosi_s};
                wr_strobe <= 1'b1;
              end
              miso  <= 1'b0;
              state <= HOLD;
            end
          end else if (sck_fall) begin
            if (first_fall) begin
              tx_sr      <= rd_data;
              miso       <= rd_data[7];
              first_fall <= 1'b0;
            end else begin
              tx_sr <= {tx_sr[6:0], 1'b0};
              miso  <= tx_sr[6];
            end
          end
        end

        HOLD: begin
          miso <= 1'b0;
          if (cs_s) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          miso  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_reg_port
// Purpose  : Self-checking bench for spi_reg_port. Acts as SPI master and as
//            the register selector; expected values come from a byte-array
//            model of the register file updated by the frames the bench sends.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_port;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = SYNC_STAGES + 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       miso_oe;
  logic [7:0] addr;
  logic [7:0] rd_data;
  logic [7:0] wr_data;
  logic       wr_strobe;
  logic       rd_strobe;

  logic [7:0] sel_mem   [0:255];
  logic [7:0] model_mem [0:255];

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int order_q[$];
  logic prev_wr = 1'b0;
  logic prev_rd = 1'b0;
  logic [7:0] last_wr = 8'h00;

  spi_reg_port #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sck      (sck),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .addr     (addr),
    .rd_data  (rd_data),
    .wr_data  (wr_data),
    .wr_strobe(wr_strobe),
    .rd_strobe(rd_strobe)
  );

  always #5 clk = ~clk;

  // Register selector seen by the DUT.
  assign rd_data = sel_mem[addr];
  always @(posedge clk) if (wr_strobe) sel_mem[addr] = wr_data;

  // Strobe monitor: counts pulses, logs their order, checks their shape.
  always @(negedge clk) begin
    if (wr_strobe || rd_strobe) begin
      tests++;
      assert (!(wr_strobe && rd_strobe) && !(wr_strobe && prev_wr) && !(rd_strobe && prev_rd))
      else begin
        fails++;
        $error("FAIL strobe_shape: wr=%0b rd=%0b prev_wr=%0b prev_rd=%0b, required exclusive 1-clk pulses",
               wr_strobe, rd_strobe, prev_wr, prev_rd);
      end
      if (wr_strobe) begin wr_cnt++; order_q.push_back(1); end
      if (rd_strobe) begin rd_cnt++; order_q.push_back(2); end
    end
    prev_wr = wr_strobe;
    prev_rd = rd_strobe;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mode 0: mosi set while sck low, miso sampled just before the rise.
  task automatic spi_bits(input logic [7:0] out, input int n, output logic [7:0] in);
    in = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = out[7-i];
      tick(HALF);
      in = {in[6:0], miso};
      sck = 1'b1;
      tick(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [7:0] data,
                           input int extra, input int gap);
    logic [7:0] cmd_rx, data_rx, junk, exp_rd;
    int w0, r0;
    w0 = wr_cnt;
    r0 = rd_cnt;
    exp_rd = model_mem[{1'b0, cmd[6:0]}];
    cs_n = 1'b0;
    tick(SYNC_STAGES + 3);
    spi_bits(cmd, 8, cmd_rx);
    spi_bits(data, 8, data_rx);
    for (int k = 0; k < extra; k++) spi_bits(8'hFF, 8, junk);
    tick(HALF);
    cs_n = 1'b1;
    tick(gap);
    check({tag, "_addr"}, addr, {1'b0, cmd[6:0]});
    check({tag, "_miso_cmd"}, cmd_rx, 8'h00);
    if (cmd[7]) begin
      model_mem[{1'b0, cmd[6:0]}] = data;
      last_wr = data;
      check({tag, "_wr_data"}, wr_data, data);
      check({tag, "_wr_cnt"}, wr_cnt - w0, 1);
      check({tag, "_rd_cnt"}, rd_cnt - r0, 0);
    end else begin
      check({tag, "_miso_byte"}, data_rx, exp_rd);
      check({tag, "_rd_cnt"}, rd_cnt - r0, 1);
      check({tag, "_wr_cnt"}, wr_cnt - w0, 0);
    end
  endtask

  initial begin
    logic [7:0] v, junk, rcmd, rdat;
    int w0, r0, n0;

    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      sel_mem[i] = v;
      model_mem[i] = v;
    end

    // Reset values
    tick(4);
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_addr", addr, 8'h00);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_rd_strobe", rd_strobe, 0);
    rst_n = 1'b1;
    tick(8);

    // Read of address 0 returning 0xA5
    sel_mem[0] = 8'hA5;
    model_mem[0] = 8'hA5;
    run_frame("rd00", 8'h00, 8'h00, 0, 10);

    // Write 0x5C to 0x23
    run_frame("wrA3", 8'hA3, 8'h5C, 0, 10);

    // Write to 0x36 aborted after 5 data bits
    w0 = wr_cnt;
    cs_n = 1'b0;
    tick(SYNC_STAGES + 3);
    spi_bits(8'hB6, 8, junk);
    spi_bits(8'hFF, 5, junk);
    tick(2);
    cs_n = 1'b1;
    tick(SYNC_STAGES + 3);
    check("abort_wr_cnt", wr_cnt - w0, 0);
    check("abort_wr_data", wr_data, last_wr);
    check("abort_miso", miso, 0);
    check("abort_miso_oe", miso_oe, 0);
    check("abort_addr", addr, 8'h36);
    tick(10);

    // 24 sck cycles in one write frame
    run_frame("wr24", 8'hA6, 8'h11, 1, 10);

    // Reset during bit 3 of cmd, cs_n held low through release
    cs_n = 1'b0;
    tick(SYNC_STAGES + 3);
    spi_bits(8'h26, 3, junk);
    mosi = 1'b0;
    tick(2);
    rst_n = 1'b0;
    tick(2);
    check("mid_rst_miso", miso, 0);
    check("mid_rst_miso_oe", miso_oe, 0);
    check("mid_rst_addr", addr, 8'h00);
    check("mid_rst_wr_data", wr_data, 8'h00);
    check("mid_rst_strobes", {wr_strobe, rd_strobe}, 2'b00);
    rst_n = 1'b1;
    w0 = wr_cnt;
    r0 = rd_cnt;
    spi_bits(8'h00, 8, junk);
    spi_bits(8'h00, 8, junk);
    check("unarmed_strobes", (wr_cnt - w0) + (rd_cnt - r0), 0);
    check("unarmed_addr", addr, 8'h00);
    cs_n = 1'b1;
    tick(10);
    run_frame("rd26", 8'h26, 8'h00, 0, 10);

    // Back-to-back write then read of 0x47 with a short cs_n gap
    n0 = order_q.size();
    run_frame("b2b_wr", 8'hC7, 8'h80, 0, SYNC_STAGES + 2);
    run_frame("b2b_rd", 8'h47, 8'h00, 0, 10);
    check("b2b_order0", order_q.size() > n0     ? order_q[n0]   : 0, 1);
    check("b2b_order1", order_q.size() > n0 + 1 ? order_q[n0+1] : 0, 2);

    // Random frames against the register-file model
    for (int t = 0; t < 12; t++) begin
      rcmd = 8'($urandom);
      rdat = 8'($urandom);
      run_frame("rand", rcmd, rdat, 0, 8 + int'($urandom_range(0, 4)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
